// File: rtl/lcd_pkg.sv
// Shared definitions for the BPM character-LCD driver.
// Holds the controller state encoding, the transfer sub-phase encoding, the
// HD44780 command bytes, the ASCII constants, and two helpers that produce
// the init command list and the "NNN BPM" write list entries.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StInit,
    StIdle,
    StConv,
    StWrite
  } lcd_state_e;

  // Per-transfer sequencing: setup cycle, strobe (lcd_e high), then the
  // fall cycle plus command wait, counted together.
  typedef enum logic [1:0] {
    PhSetup,
    PhStrobe,
    PhWait
  } xfer_phase_e;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [2:0] INIT_LAST  = 3'd3;
  localparam logic [2:0] WRITE_LAST = 3'd7;

  // Init command by position; the last one is the clear.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0:    cmd = LCD_FUNC_SET;
      3'd1:    cmd = LCD_DISP_ON;
      3'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Write list entry as {rs, data}. Leading zeros of the value are blanked,
  // the units digit is always printed.
  function automatic logic [8:0] write_entry(input logic [2:0] idx,
                                             input logic [1:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] u,
                                             input logic [3:0] col);
    logic [8:0] ent;
    case (idx)
      3'd0:    ent = {1'b0, LCD_SET_DDRAM | {4'h0, col}};
      3'd1:    ent = (h == 2'd0) ? {1'b1, ASCII_SPACE} : {1'b1, ASCII_ZERO + {6'd0, h}};
      3'd2:    ent = (h == 2'd0 && t == 4'd0) ? {1'b1, ASCII_SPACE}
                                               : {1'b1, ASCII_ZERO + {4'd0, t}};
      3'd3:    ent = {1'b1, ASCII_ZERO + {4'd0, u}};
      3'd4:    ent = {1'b1, ASCII_SPACE};
      3'd5:    ent = {1'b1, 8'h42};
      3'd6:    ent = {1'b1, 8'h50};
      default: ent = {1'b1, 8'h4D};
    endcase
    return ent;
  endfunction

endpackage

// File: rtl/lcd_bpm_display_bin2bcd.sv
// Sequential 8-bit binary to BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, captures bin
//   bin [7:0]         value to convert
//   done              one-cycle pulse when the digits are valid
//   hundreds [1:0]    0..2
//   tens, units [3:0] 0..9
// Digits stay stable after done until the next start.
module bin2bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // {hundreds[17:16], tens[15:12], units[11:8], binary[7:0]}
  logic [17:0] sh_q, sh_d, step;
  logic [2:0]  it_q, it_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  always_comb begin
    step = sh_q;
    if (step[11:8] >= 4'd5)  step[11:8]  = step[11:8] + 4'd3;
    if (step[15:12] >= 4'd5) step[15:12] = step[15:12] + 4'd3;
    step = {step[16:0], 1'b0};
  end

  always_comb begin
    sh_d   = sh_q;
    it_d   = it_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = {10'd0, bin};
      it_d  = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d = step;
      it_d = it_q + 3'd1;
      if (it_q == 3'd7) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      it_q   <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      it_q   <= it_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign hundreds = sh_q[17:16];
  assign tens     = sh_q[15:12];
  assign units    = sh_q[11:8];

endmodule

// File: rtl/lcd_bpm_display.sv
// HD44780 8-bit parallel driver showing a heart-rate value as "NNN BPM".
// After reset: power-up wait, init commands, then idle. A send_lcd request in
// idle latches bus_lcd, converts it to decimal and writes the text at LCD_COL.
// Ports:
//   clk_core, reset   clock, asynchronous active-low reset
//   bus_lcd [7:0]     BPM value; send_lcd request (sampled only in idle)
//   busy_lcd          high while initialising or updating the panel
//   lcd_rs/rw/e/data  panel bus (rw tied low, write only)
// All panel outputs are registered; reset clears lcd_e asynchronously.
module lcd_bpm_display
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_E_PULSE = 12,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 80000,
  parameter int unsigned LCD_COL   = 0
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic [7:0] bus_lcd,
  input  logic       send_lcd,
  output logic       busy_lcd,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned MaxA = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int unsigned MaxB = (MaxA > T_CMD) ? MaxA : T_CMD;
  localparam int unsigned MaxC = (MaxB > T_E_PULSE) ? MaxB : T_E_PULSE;
  // Wait phase counts 0..limit inclusive (fall cycle + wait), hence +2.
  localparam int unsigned CntW = $clog2(MaxC + 2);

  localparam logic [CntW-1:0] PwrLast = CntW'(T_POWERUP - 1);
  localparam logic [CntW-1:0] ELast   = CntW'(T_E_PULSE - 1);
  localparam logic [CntW-1:0] CmdLim  = CntW'(T_CMD);
  localparam logic [CntW-1:0] ClrLim  = CntW'(T_CLEAR);
  localparam logic [3:0]      ColBits = 4'(LCD_COL);

  lcd_state_e      st_q, st_d;
  xfer_phase_e     ph_q, ph_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      value_q, value_d;
  logic            busy_q, busy_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic [8:0]      list_q [8];
  logic [8:0]      list_d [8];

  logic            bcd_start;
  logic            bcd_done;
  logic [1:0]      bcd_h;
  logic [3:0]      bcd_t;
  logic [3:0]      bcd_u;

  logic [CntW-1:0] wait_lim;
  logic            last_item;
  logic [8:0]      next_item;

  bin2bcd u_bin2bcd (
    .clk      (clk_core),
    .rst_n    (reset),
    .start    (bcd_start),
    .bin      (value_q),
    .done     (bcd_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u)
  );

  // Only the clear command needs the long wait.
  always_comb begin
    wait_lim  = CmdLim;
    last_item = 1'b0;
    next_item = list_q[idx_q + 3'd1];
    if (st_q == StInit) begin
      last_item = (idx_q == INIT_LAST);
      next_item = {1'b0, init_cmd(idx_q + 3'd1)};
      if (idx_q == INIT_LAST) wait_lim = ClrLim;
    end else begin
      last_item = (idx_q == WRITE_LAST);
    end
  end

  always_comb begin
    st_d      = st_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    value_d   = value_q;
    busy_d    = busy_q;
    e_d       = e_q;
    rs_d      = rs_q;
    data_d    = data_q;
    list_d    = list_q;
    bcd_start = 1'b0;

    unique case (st_q)
      StPwrup: begin
        if (cnt_q == PwrLast) begin
          st_d           = StInit;
          ph_d           = PhSetup;
          cnt_d          = '0;
          idx_d          = 3'd0;
          {rs_d, data_d} = {1'b0, init_cmd(3'd0)};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StInit, StWrite: begin
        unique case (ph_q)
          PhSetup: begin
            e_d   = 1'b1;
            ph_d  = PhStrobe;
            cnt_d = '0;
          end
          PhStrobe: begin
            if (cnt_q == ELast) begin
              e_d   = 1'b0;
              ph_d  = PhWait;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PhWait: begin
            if (cnt_q == wait_lim) begin
              cnt_d = '0;
              if (last_item) begin
                st_d   = StIdle;
                busy_d = 1'b0;
              end else begin
                idx_d          = idx_q + 3'd1;
                ph_d           = PhSetup;
                {rs_d, data_d} = next_item;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: ph_d = PhSetup;
        endcase
      end

      StIdle: begin
        busy_d = 1'b0;
        if (send_lcd) begin
          value_d = bus_lcd;
          st_d    = StConv;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
        end
      end

      StConv: begin
        // idx_q doubles as a "converter started" flag here.
        if (idx_q == 3'd0) begin
          bcd_start = 1'b1;
          idx_d     = 3'd1;
        end else if (bcd_done) begin
          for (int i = 0; i < 8; i++) begin
            list_d[i] = write_entry(3'(i), bcd_h, bcd_t, bcd_u, ColBits);
          end
          st_d           = StWrite;
          ph_d           = PhSetup;
          cnt_d          = '0;
          idx_d          = 3'd0;
          {rs_d, data_d} = write_entry(3'd0, bcd_h, bcd_t, bcd_u, ColBits);
        end
      end

      default: st_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset) begin
    if (!reset) begin
      st_q    <= StPwrup;
      ph_q    <= PhSetup;
      cnt_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      busy_q  <= 1'b1;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < 8; i++) list_q[i] <= '0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      list_q  <= list_d;
    end
  end

  assign busy_lcd = busy_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_bpm_display.sv
// Self-checking bench for lcd_bpm_display with short timing parameters.
// A negedge monitor captures every lcd_e transfer and checks strobe width and
// bus stability; the main sequence compares captured frames with text built
// by formatting the value as "%3d BPM".
module tb_lcd_bpm_display;

  localparam int unsigned TPw  = 20;
  localparam int unsigned TE   = 2;
  localparam int unsigned TCmd = 5;
  localparam int unsigned TClr = 10;

  typedef logic [8:0] xfer_t;
  typedef xfer_t xq_t[$];

  logic       clk_core = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] bus_lcd  = 8'd0;
  logic       send_lcd = 1'b0;
  logic       busy_lcd;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_bpm_display #(
    .T_POWERUP (TPw),
    .T_E_PULSE (TE),
    .T_CMD     (TCmd),
    .T_CLEAR   (TClr),
    .LCD_COL   (0)
  ) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .bus_lcd  (bus_lcd),
    .send_lcd (send_lcd),
    .busy_lcd (busy_lcd),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk_core = ~clk_core;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Transfer monitor
  xfer_t xfers[$];
  int    rise_cyc[$];
  int    last_fall = 0;
  logic  e_prev = 1'b0;
  int    width = 0;
  xfer_t cap = '0;
  xfer_t prev = '0;

  always @(negedge clk_core) begin
    if (!reset) begin
      e_prev = 1'b0;
      width  = 0;
      prev   = '0;
    end else begin
      chk("rw_low", {31'd0, lcd_rw}, 32'd0);
      if (lcd_e && !e_prev) begin
        chk("setup_before_rise", {23'd0, lcd_rs, lcd_data}, {23'd0, prev});
        cap   = {lcd_rs, lcd_data};
        width = 1;
        xfers.push_back(cap);
        rise_cyc.push_back(cyc);
      end else if (lcd_e) begin
        width++;
        chk("stable_strobe", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
      end else if (e_prev) begin
        chk("e_width", width, TE);
        chk("stable_fall", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
        last_fall = cyc;
      end
      e_prev = lcd_e;
      prev   = {lcd_rs, lcd_data};
    end
  end

  function automatic xq_t frame_model(input int v);
    xq_t   q;
    string s;
    s = $sformatf("%3d BPM", v);
    q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 7; i++) q.push_back({1'b1, s[i]});
    return q;
  endfunction

  task automatic wait_busy(input logic lvl, input int bound, input string tag);
    int n = 0;
    while (busy_lcd !== lvl && n < bound) begin
      @(negedge clk_core);
      n++;
    end
    chk(tag, {31'd0, busy_lcd}, {31'd0, lvl});
  endtask

  task automatic compare_frame(input int v, input int offset);
    xq_t exp_q;
    exp_q = frame_model(v);
    for (int i = 0; i < 8; i++) begin
      if (offset + i < xfers.size())
        chk($sformatf("frame_v%0d_item%0d", v, i), {23'd0, xfers[offset + i]},
            {23'd0, exp_q[i]});
    end
  endtask

  task automatic check_init(input int c0);
    xfer_t init_exp[4];
    init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
    wait_busy(1'b0, 3000, "init_done");
    chk("init_count", xfers.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < xfers.size())
        chk($sformatf("init_cmd%0d", i), {23'd0, xfers[i]}, {23'd0, init_exp[i]});
    end
    if (rise_cyc.size() > 0) chk("init_first_rise", rise_cyc[0] - c0, TPw + 1);
    chk("init_busy_fall", cyc - last_fall, TClr + 1);
  endtask

  // Starts a frame from idle (at a negedge) and checks it to completion.
  task automatic run_frame(input logic [7:0] v);
    xfers.delete();
    bus_lcd  = v;
    send_lcd = 1'b1;
    @(negedge clk_core);
    chk("busy_rise", {31'd0, busy_lcd}, 32'd1);
    send_lcd = 1'b0;
    wait_busy(1'b0, 3000, "frame_done");
    chk("frame_len", xfers.size(), 8);
    chk("frame_busy_fall", cyc - last_fall, TCmd + 1);
    compare_frame(v, 0);
    @(negedge clk_core);
  endtask

  task automatic wait_xfers(input int n, input logic need_e, input string tag);
    int k = 0;
    while (!(xfers.size() >= n && (!need_e || lcd_e)) && k < 3000) begin
      @(negedge clk_core);
      k++;
    end
    chk(tag, {31'd0, (k < 3000)}, 32'd1);
  endtask

  initial begin
    int   c0;
    int   v;
    int   dir_vals[6];
    dir_vals = '{72, 0, 255, 105, 7, 50};

    // Reset values
    #12;
    chk("rst_busy", {31'd0, busy_lcd}, 32'd1);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);

    @(negedge clk_core);
    xfers.delete();
    rise_cyc.delete();
    reset = 1'b1;
    c0 = cyc;
    check_init(c0);
    @(negedge clk_core);

    // Directed boundary values
    for (int i = 0; i < 6; i++) run_frame(8'(dir_vals[i]));

    // Random values
    for (int i = 0; i < 6; i++) run_frame(8'($urandom_range(0, 255)));

    // Request during a write is ignored and not queued
    v = $urandom_range(0, 199);
    xfers.delete();
    bus_lcd  = 8'(v);
    send_lcd = 1'b1;
    @(negedge clk_core);
    send_lcd = 1'b0;
    wait_xfers(3, 1'b0, "midwrite_reach");
    bus_lcd  = 8'd200;
    send_lcd = 1'b1;
    @(negedge clk_core);
    send_lcd = 1'b0;
    wait_busy(1'b0, 3000, "midwrite_done");
    compare_frame(v, 0);
    repeat (60) @(negedge clk_core);
    chk("no_queued_frame", xfers.size(), 8);
    chk("idle_after_ignore", {31'd0, busy_lcd}, 32'd0);

    // Held request gives back-to-back frames
    xfers.delete();
    bus_lcd  = 8'd60;
    send_lcd = 1'b1;
    wait_busy(1'b1, 5, "b2b_start");
    wait_busy(1'b0, 3000, "b2b_first_done");
    chk("b2b_first_fall", cyc - last_fall, TCmd + 1);
    @(negedge clk_core);
    chk("b2b_restart", {31'd0, busy_lcd}, 32'd1);
    send_lcd = 1'b0;
    wait_busy(1'b0, 3000, "b2b_second_done");
    chk("b2b_len", xfers.size(), 16);
    compare_frame(60, 0);
    compare_frame(60, 8);
    @(negedge clk_core);

    // Reset during a strobe aborts and reruns init
    xfers.delete();
    bus_lcd  = 8'd123;
    send_lcd = 1'b1;
    @(negedge clk_core);
    send_lcd = 1'b0;
    wait_xfers(2, 1'b1, "abort_reach_strobe");
    #2;
    reset = 1'b0;
    #1;
    chk("abort_e", {31'd0, lcd_e}, 32'd0);
    chk("abort_busy", {31'd0, busy_lcd}, 32'd1);
    chk("abort_rs", {31'd0, lcd_rs}, 32'd0);
    chk("abort_data", {24'd0, lcd_data}, 32'd0);
    @(negedge clk_core);
    @(negedge clk_core);
    xfers.delete();
    rise_cyc.delete();
    reset = 1'b1;
    c0 = cyc;
    check_init(c0);
    @(negedge clk_core);
    run_frame(8'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
